ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline stage of the five-stage MIPS datapath, directly downstream of the 32-bit ALU. It registers the ALU result and control bits for the memory stage and resolves conditional branches from the ALU result and zero flag. It also generates store byte-enables, replicates store data and flags misaligned accesses. It drives the PC-source redirect back to fetch and squashes the wrong-path instruction that follows a taken branch.

## Interface
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold all stage registers.
- Flush  in  1  capture a bubble this edge.
- ValidIn  in  1  EX holds a real instruction.
- ALUResult  in  32  ALU output: address, data or branch compare.
- Zero  in  1  ALU zero flag.
- BranchType  in  3  000 none, 001 beq, 010 bne, 011 bgez, 100 bgtz, 101 blez, 110 bltz, 111 reserved (treated as none).
- BranchTarget  in  32  precomputed target PC.
- RtData  in  32  store data.
- MemRead, MemWrite, RegWrite, MemToReg  in  1 each  EX control bits.
- MemSize  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- WriteReg  in  5  destination register.
- ValidOut  out  1  MEM holds a real instruction.
- ALUResultOut  out  32  registered ALU result.
- StoreData  out  32  lane-replicated store data.
- ByteEn  out  4  store byte enables, lane 0 = address[1:0]==0.
- MemReadOut, MemWriteOut, RegWriteOut, MemToRegOut  out  1 each  gated control bits.
- MemSizeOut  out  2  registered MemSize.
- WriteRegOut  out  5  registered WriteReg.
- PCSrc  out  1  redirect fetch to BranchTargetOut.
- BranchTargetOut  out  32  registered target.
- MisalignErr  out  1  sticky misalignment flag.
- TakenCount  out  CNT_W  saturating count of taken branches.

## Operation
Capture priority is Reset > Stall > Flush/squash > normal capture.
- **Reset:**
  - Every output becomes 0, including TakenCount and MisalignErr.
  - Reset overrides Stall and Flush in the same cycle.
- **Stall:** every register holds, including PCSrc, TakenCount and MisalignErr.
- **Effective valid:** V = ValidIn & ~Flush & ~PCSrc, where PCSrc is the current registered value.
  - The instruction behind a taken branch is therefore captured as a bubble.
- **Bubble capture (V=0):**
  - ValidOut, PCSrc and all control outputs become 0.
  - ByteEn becomes 0000.
  - Data outputs hold their previous values (don't care).
- **Branch taken, T:**
  - beq: Zero=1.
  - bne: Zero=0.
  - bgez, bgtz, blez, bltz: ALUResult[0]=1, since the ALU returns 1 or 0 for these.
  - none or reserved: never taken.
- **Branch register updates on a V=1 capture:**
  - PCSrc <= T.
  - BranchTargetOut <= BranchTarget.
  - TakenCount increments when T=1 and saturates at all-ones.
- **Misalignment, M**, computed from A = ALUResult[1:0]:
  - Word: A != 00.
  - Half: A[0] = 1.
  - Byte: never misaligned.
- **Memory access gating:**
  - MemReadOut <= MemRead & ~M.
  - MemWriteOut <= MemWrite & ~M.
  - MisalignErr sets when V & (MemRead|MemWrite) & M, and clears only on Reset.
- **Stores:**
  - StoreData: word passes RtData; half gives {2{RtData[15:0]}}; byte gives {4{RtData[7:0]}}.
  - ByteEn when MemWriteOut is set: word 1111; half 0011 (A[1]=0) or 1100 (A[1]=1); byte 0001 << A.
  - ByteEn is 0000 otherwise, including for loads.
- RegWriteOut, MemToRegOut, WriteRegOut, ALUResultOut and MemSizeOut register directly when V=1.

## Timing
- Latency is one cycle: inputs sampled at edge n appear at the outputs after edge n.
- PCSrc is high for exactly one unstalled cycle per taken branch.
  - Under Stall it stays high for the whole stall; fetch redirects to the same target, which is idempotent.
- Squash timing:
  - The wrong-path instruction is the one presented while PCSrc=1.
  - It is dropped at the first unstalled edge.
  - The instruction after it is captured normally.
- Flush coinciding with a taken branch in EX drops the branch: no PCSrc and no count.
- All outputs are registers, with no combinational path from input to output.

## Test plan
- **Reset:** Reset=1 with Stall=1 and ValidIn=1 -> all outputs 0 on the next cycle.
- **beq then squash:**
  - ValidIn=1, BranchType=001, Zero=1, BranchTarget=0x0040_0100 -> PCSrc=1 and BranchTargetOut=0x0040_0100 after one edge.
  - The next valid RegWrite=1 instruction is captured with ValidOut=0 and RegWriteOut=0.
  - TakenCount=1.
- **bltz not taken:** BranchType=110, ALUResult=0 -> PCSrc=0 and TakenCount unchanged.
- **Half store at offset 2:** MemWrite=1, MemSize=01, ALUResult=0x1002, RtData=0xDEAD_BEEF -> StoreData=0xBEEF_BEEF, ByteEn=1100, MisalignErr=0.
- **Misaligned word load:** MemRead=1, MemSize=00, ALUResult=0x1001 -> MemReadOut=0 and MisalignErr=1.
  - MisalignErr stays 1 through later aligned accesses until Reset.
- **Stall and saturation:**
  - Stall=1 for 3 cycles with a taken branch registered -> PCSrc and all outputs frozen for 3 cycles, then one squash on release.
  - With CNT_W=2, 5 taken branches -> TakenCount=3.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers the ALU result and control bits for MEM,
// resolves conditional branches, builds store lanes/byte enables, gates
// misaligned accesses and squashes the wrong-path slot after a taken branch.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              Zero,
  input  logic [2:0]        BranchType,
  input  logic [DATA_W-1:0] BranchTarget,
  input  logic [DATA_W-1:0] RtData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemToReg,
  input  logic [1:0]        MemSize,
  input  logic [4:0]        WriteReg,
  output logic              ValidOut,
  output logic [DATA_W-1:0] ALUResultOut,
  output logic [DATA_W-1:0] StoreData,
  output logic [3:0]        ByteEn,
  output logic              MemReadOut,
  output logic              MemWriteOut,
  output logic              RegWriteOut,
  output logic              MemToRegOut,
  output logic [1:0]        MemSizeOut,
  output logic [4:0]        WriteRegOut,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTargetOut,
  output logic              MisalignErr,
  output logic [CNT_W-1:0]  TakenCount
);

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [3:0]        be_q, be_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic              rwr_q, rwr_d;
  logic              m2r_q, m2r_d;
  logic [1:0]        size_q, size_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] btgt_q, btgt_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              eff_valid;
  logic              taken;
  logic              misalign;
  logic [1:0]        addr_lo;
  logic [DATA_W-1:0] lane_data;
  logic [3:0]        lane_be;

  // Branch resolution, misalignment and store-lane generation from EX inputs
  always_comb begin
    addr_lo   = ALUResult[1:0];
    // The slot presented while a redirect is outstanding is wrong-path.
    eff_valid = ValidIn & ~Flush & ~pcsrc_q;

    taken = 1'b0;
    case (BranchType)
      BR_BEQ:  taken = Zero;
      BR_BNE:  taken = ~Zero;
      BR_BGEZ, BR_BGTZ, BR_BLEZ, BR_BLTZ: taken = ALUResult[0];
      default: taken = 1'b0;
    endcase

    // Reserved size 11 behaves as a word access.
    case (MemSize)
      SZ_HALF: begin
        misalign  = addr_lo[0];
        lane_data = {2{RtData[15:0]}};
        lane_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: begin
        misalign  = 1'b0;
        lane_data = {4{RtData[7:0]}};
        lane_be   = 4'b0001 << addr_lo;
      end
      default: begin
        misalign  = (addr_lo != 2'b00);
        lane_data = RtData;
        lane_be   = 4'b1111;
      end
    endcase
  end

  // Next-state for all stage registers; bubbles clear control, hold data
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    sdata_d = sdata_q;
    be_d    = be_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    rwr_d   = rwr_q;
    m2r_d   = m2r_q;
    size_d  = size_q;
    wreg_d  = wreg_q;
    pcsrc_d = pcsrc_q;
    btgt_d  = btgt_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    if (eff_valid) begin
      valid_d = 1'b1;
      alu_d   = ALUResult;
      sdata_d = lane_data;
      mrd_d   = MemRead & ~misalign;
      mwr_d   = MemWrite & ~misalign;
      be_d    = (MemWrite & ~misalign) ? lane_be : 4'b0000;
      rwr_d   = RegWrite;
      m2r_d   = MemToReg;
      size_d  = MemSize;
      wreg_d  = WriteReg;
      pcsrc_d = taken;
      btgt_d  = BranchTarget;
      if ((MemRead | MemWrite) & misalign)
        mis_d = 1'b1;
      if (taken && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
    end else begin
      valid_d = 1'b0;
      mrd_d   = 1'b0;
      mwr_d   = 1'b0;
      be_d    = 4'b0000;
      rwr_d   = 1'b0;
      m2r_d   = 1'b0;
      pcsrc_d = 1'b0;
    end
  end

  // Stage registers: reset clears everything, stall holds everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      sdata_q <= '0;
      be_q    <= 4'b0000;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      rwr_q   <= 1'b0;
      m2r_q   <= 1'b0;
      size_q  <= 2'b00;
      wreg_q  <= 5'd0;
      pcsrc_q <= 1'b0;
      btgt_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!Stall) begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      sdata_q <= sdata_d;
      be_q    <= be_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      rwr_q   <= rwr_d;
      m2r_q   <= m2r_d;
      size_q  <= size_d;
      wreg_q  <= wreg_d;
      pcsrc_q <= pcsrc_d;
      btgt_q  <= btgt_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ValidOut        = valid_q;
  assign ALUResultOut    = alu_q;
  assign StoreData       = sdata_q;
  assign ByteEn          = be_q;
  assign MemReadOut      = mrd_q;
  assign MemWriteOut     = mwr_q;
  assign RegWriteOut     = rwr_q;
  assign MemToRegOut     = m2r_q;
  assign MemSizeOut      = size_q;
  assign WriteRegOut     = wreg_q;
  assign PCSrc           = pcsrc_q;
  assign BranchTargetOut = btgt_q;
  assign MisalignErr     = mis_q;
  assign TakenCount      = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ex_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, ValidIn, Zero;
  logic [31:0] ALUResult, BranchTarget, RtData;
  logic [2:0]  BranchType;
  logic        MemRead, MemWrite, RegWrite, MemToReg;
  logic [1:0]  MemSize;
  logic [4:0]  WriteReg;

  logic        ValidOut, MemReadOut, MemWriteOut, RegWriteOut, MemToRegOut;
  logic        PCSrc, MisalignErr;
  logic [31:0] ALUResultOut, StoreData, BranchTargetOut;
  logic [3:0]  ByteEn;
  logic [1:0]  MemSizeOut;
  logic [4:0]  WriteRegOut;
  logic [15:0] TakenCount;

  logic        s_valid, s_mrd, s_mwr, s_rwr, s_m2r, s_pcsrc, s_mis;
  logic [31:0] s_alu, s_sd, s_bt;
  logic [3:0]  s_be;
  logic [1:0]  s_size;
  logic [4:0]  s_wr;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  ex_mem_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .ALUResult(ALUResult), .Zero(Zero), .BranchType(BranchType),
    .BranchTarget(BranchTarget), .RtData(RtData), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemSize(MemSize), .WriteReg(WriteReg), .ValidOut(ValidOut),
    .ALUResultOut(ALUResultOut), .StoreData(StoreData), .ByteEn(ByteEn),
    .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .MemSizeOut(MemSizeOut), .WriteRegOut(WriteRegOut), .PCSrc(PCSrc),
    .BranchTargetOut(BranchTargetOut), .MisalignErr(MisalignErr),
    .TakenCount(TakenCount)
  );

  // Narrow-counter instance to exercise saturation.
  ex_mem_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .ALUResult(ALUResult), .Zero(Zero), .BranchType(BranchType),
    .BranchTarget(BranchTarget), .RtData(RtData), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemSize(MemSize), .WriteReg(WriteReg), .ValidOut(s_valid),
    .ALUResultOut(s_alu), .StoreData(s_sd), .ByteEn(s_be),
    .MemReadOut(s_mrd), .MemWriteOut(s_mwr),
    .RegWriteOut(s_rwr), .MemToRegOut(s_m2r),
    .MemSizeOut(s_size), .WriteRegOut(s_wr), .PCSrc(s_pcsrc),
    .BranchTargetOut(s_bt), .MisalignErr(s_mis),
    .TakenCount(s_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_valid, m_mr, m_mw, m_rw, m_m2r, m_pcsrc, m_mis;
  logic [31:0] m_alu, m_sd, m_bt;
  logic [3:0]  m_be;
  logic [1:0]  m_size;
  logic [4:0]  m_wr;
  int          m_cnt, m_cnt2;

  function automatic bit f_taken(input logic [2:0] bt, input logic z, input logic [31:0] a);
    if (bt == 3'd1) return z;
    if (bt == 3'd2) return !z;
    if (bt >= 3'd3 && bt <= 3'd6) return a[0];
    return 0;
  endfunction

  function automatic int f_bytes(input logic [1:0] sz);
    if (sz == 2'd1) return 2;
    if (sz == 2'd2) return 1;
    return 4;
  endfunction

  always @(posedge Clk) begin
    bit v, t, mis;
    int nb, off;
    if (Reset) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_pcsrc = 0; m_mis = 0;
      m_alu = 0; m_sd = 0; m_bt = 0; m_be = 0; m_size = 0; m_wr = 0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (!Stall) begin
      v = ValidIn && !Flush && !m_pcsrc;
      if (v) begin
        nb  = f_bytes(MemSize);
        off = int'(ALUResult[1:0]);
        mis = (off % nb) != 0;
        t   = f_taken(BranchType, Zero, ALUResult);
        m_valid = 1;
        m_pcsrc = t;
        m_bt    = BranchTarget;
        if (t) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        m_mr  = MemRead && !mis;
        m_mw  = MemWrite && !mis;
        m_rw  = RegWrite;
        m_m2r = MemToReg;
        m_wr  = WriteReg;
        m_alu = ALUResult;
        m_size = MemSize;
        if (nb == 4) m_sd = RtData;
        else if (nb == 2) m_sd = {RtData[15:0], RtData[15:0]};
        else m_sd = {RtData[7:0], RtData[7:0], RtData[7:0], RtData[7:0]};
        m_be = m_mw ? 4'(((1 << nb) - 1) << off) : 4'b0000;
        if ((MemRead || MemWrite) && mis) m_mis = 1;
      end else begin
        m_valid = 0; m_pcsrc = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_be = 0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("ValidOut", 32'(ValidOut), 32'(m_valid));
      chk("PCSrc", 32'(PCSrc), 32'(m_pcsrc));
      chk("MemReadOut", 32'(MemReadOut), 32'(m_mr));
      chk("MemWriteOut", 32'(MemWriteOut), 32'(m_mw));
      chk("RegWriteOut", 32'(RegWriteOut), 32'(m_rw));
      chk("MemToRegOut", 32'(MemToRegOut), 32'(m_m2r));
      chk("ByteEn", 32'(ByteEn), 32'(m_be));
      chk("MisalignErr", 32'(MisalignErr), 32'(m_mis));
      chk("TakenCount", 32'(TakenCount), 32'(m_cnt));
      chk("sat_TakenCount", 32'(s_cnt), 32'(m_cnt2));
      chk("sat_ValidOut", 32'(s_valid), 32'(m_valid));
      chk("sat_PCSrc", 32'(s_pcsrc), 32'(m_pcsrc));
      if (m_valid) begin
        chk("ALUResultOut", ALUResultOut, m_alu);
        chk("StoreData", StoreData, m_sd);
        chk("BranchTargetOut", BranchTargetOut, m_bt);
        chk("MemSizeOut", 32'(MemSizeOut), 32'(m_size));
        chk("WriteRegOut", 32'(WriteRegOut), 32'(m_wr));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Reset = 0; Stall = 0; Flush = 0; ValidIn = 0; Zero = 0;
    ALUResult = 32'h0; BranchTarget = 32'h0; RtData = 32'h0; BranchType = 3'd0;
    MemRead = 0; MemWrite = 0; RegWrite = 0; MemToReg = 0; MemSize = 2'd0; WriteReg = 5'd0;
  endtask

  initial begin
    idle();
    // Reset dominates Stall and a valid taken branch store
    Reset = 1; Stall = 1; ValidIn = 1; MemWrite = 1; BranchType = 3'd1; Zero = 1;
    ALUResult = 32'h1000; RtData = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("rst_ValidOut", 32'(ValidOut), 32'd0);
    chk("rst_PCSrc", 32'(PCSrc), 32'd0);
    chk("rst_TakenCount", 32'(TakenCount), 32'd0);
    chk("rst_MisalignErr", 32'(MisalignErr), 32'd0);
    chk("rst_ByteEn", 32'(ByteEn), 32'd0);
    chk("rst_MemWriteOut", 32'(MemWriteOut), 32'd0);
    chk("rst_ALUResultOut", ALUResultOut, 32'd0);
    chk_en = 1;

    idle(); ValidIn = 1; BranchType = 3'd1; Zero = 1; BranchTarget = 32'h0040_0100;
    tick();
    chk("beq_PCSrc", 32'(PCSrc), 32'd1);
    chk("beq_Target", BranchTargetOut, 32'h0040_0100);
    chk("beq_Count", 32'(TakenCount), 32'd1);

    idle(); ValidIn = 1; RegWrite = 1; WriteReg = 5'd5;
    tick();
    chk("squash_ValidOut", 32'(ValidOut), 32'd0);
    chk("squash_RegWriteOut", 32'(RegWriteOut), 32'd0);
    chk("squash_PCSrc", 32'(PCSrc), 32'd0);
    chk("squash_Count", 32'(TakenCount), 32'd1);

    idle(); ValidIn = 1; BranchType = 3'd6; ALUResult = 32'h0;
    tick();
    chk("bltz_PCSrc", 32'(PCSrc), 32'd0);
    chk("bltz_Count", 32'(TakenCount), 32'd1);
    chk("bltz_ValidOut", 32'(ValidOut), 32'd1);

    idle(); ValidIn = 1; MemWrite = 1; MemSize = 2'd1; ALUResult = 32'h1002; RtData = 32'hDEAD_BEEF;
    tick();
    chk("half_StoreData", StoreData, 32'hBEEF_BEEF);
    chk("half_ByteEn", 32'(ByteEn), 32'hC);
    chk("half_Misalign", 32'(MisalignErr), 32'd0);
    chk("half_MemWriteOut", 32'(MemWriteOut), 32'd1);

    idle(); ValidIn = 1; MemRead = 1; MemSize = 2'd0; ALUResult = 32'h1001;
    tick();
    chk("misld_MemReadOut", 32'(MemReadOut), 32'd0);
    chk("misld_Misalign", 32'(MisalignErr), 32'd1);

    idle(); ValidIn = 1; MemRead = 1; ALUResult = 32'h1004;
    tick();
    chk("ld_MemReadOut", 32'(MemReadOut), 32'd1);
    chk("ld_MisalignSticky", 32'(MisalignErr), 32'd1);
    chk("ld_ByteEn", 32'(ByteEn), 32'd0);

    idle(); ValidIn = 1; BranchType = 3'd2; Zero = 0; BranchTarget = 32'h0040_0200;
    tick();
    chk("bne_PCSrc", 32'(PCSrc), 32'd1);
    chk("bne_Count", 32'(TakenCount), 32'd2);

    idle(); Stall = 1; ValidIn = 1; RegWrite = 1; BranchType = 3'd1; Zero = 1;
    BranchTarget = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_PCSrc", 32'(PCSrc), 32'd1);
      chk("stall_Count", 32'(TakenCount), 32'd2);
      chk("stall_Target", BranchTargetOut, 32'h0040_0200);
      chk("stall_ValidOut", 32'(ValidOut), 32'd1);
    end
    Stall = 0; BranchType = 3'd0;
    tick();
    chk("release_ValidOut", 32'(ValidOut), 32'd0);
    chk("release_PCSrc", 32'(PCSrc), 32'd0);
    chk("release_RegWriteOut", 32'(RegWriteOut), 32'd0);
    tick();
    chk("after_ValidOut", 32'(ValidOut), 32'd1);
    chk("after_RegWriteOut", 32'(RegWriteOut), 32'd1);

    for (int i = 0; i < 5; i++) begin
      idle(); ValidIn = 1; BranchType = 3'd1; Zero = 1;
      tick();
      idle(); ValidIn = 1;
      tick();
    end
    chk("sat16_Count", 32'(TakenCount), 32'd7);
    chk("sat2_Count", 32'(s_cnt), 32'd3);

    idle(); ValidIn = 1; BranchType = 3'd1; Zero = 1; Flush = 1;
    tick();
    chk("flush_PCSrc", 32'(PCSrc), 32'd0);
    chk("flush_Count", 32'(TakenCount), 32'd7);
    chk("flush_ValidOut", 32'(ValidOut), 32'd0);

    idle(); Reset = 1;
    tick();
    chk("rst2_Misalign", 32'(MisalignErr), 32'd0);
    chk("rst2_Count", 32'(TakenCount), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      Reset        = ($urandom_range(0, 99) == 0);
      Stall        = ($urandom_range(0, 4) == 0);
      Flush        = ($urandom_range(0, 9) == 0);
      ValidIn      = ($urandom_range(0, 4) != 0);
      Zero         = 1'($urandom);
      ALUResult    = $urandom;
      BranchTarget = $urandom;
      RtData       = $urandom;
      BranchType   = 3'($urandom);
      MemRead      = 1'($urandom);
      MemWrite     = 1'($urandom);
      RegWrite     = 1'($urandom);
      MemToReg     = 1'($urandom);
      MemSize      = 2'($urandom);
      WriteReg     = 5'($urandom);
      tick();
    end

    idle();
    tick();
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
